// File: rtl/vdp1_vram_arb_if.sv
// Requester / read-return / VRAM-port bundle for the VDP1 VRAM arbiter.
// master = requesters plus the VRAM controller, slave = the arbiter itself.
interface vdp1_vram_arb_if #(
  parameter int NCH      = 3,
  parameter int AW       = 18,
  parameter int DW       = 16,
  parameter int MAXBURST = 16
);
  localparam int BLW = $clog2(MAXBURST) + 1;

  logic [NCH-1:0]     REQ;
  logic [2*NCH-1:0]   REQ_WE;
  logic [AW*NCH-1:0]  REQ_A;
  logic [BLW*NCH-1:0] REQ_LEN;
  logic [DW*NCH-1:0]  REQ_D;
  logic [NCH-1:0]     GNT;
  logic [NCH-1:0]     RVALID;
  logic [DW-1:0]      RDATA;
  logic [BLW-2:0]     RIDX;
  logic [NCH-1:0]     DONE;
  logic               BUSY;
  logic [AW-1:0]      VRAM_A;
  logic [DW-1:0]      VRAM_D;
  logic [1:0]         VRAM_WE;
  logic               VRAM_RD;
  logic [DW-1:0]      VRAM_Q;
  logic               VRAM_RDY;

  modport master (
    output REQ, REQ_WE, REQ_A, REQ_LEN, REQ_D, VRAM_Q, VRAM_RDY,
    input  GNT, RVALID, RDATA, RIDX, DONE, BUSY, VRAM_A, VRAM_D, VRAM_WE, VRAM_RD
  );

  modport slave (
    input  REQ, REQ_WE, REQ_A, REQ_LEN, REQ_D, VRAM_Q, VRAM_RDY,
    output GNT, RVALID, RDATA, RIDX, DONE, BUSY, VRAM_A, VRAM_D, VRAM_WE, VRAM_RD
  );
endinterface

// File: rtl/vdp1_vram_arb.sv
// VDP1 VRAM arbiter: NCH requesters share one VRAM port (single-word writes, 1..MAXBURST read bursts).
// Define VDP1_ARB_RR_EN for round-robin arbitration; otherwise lowest channel index wins.
module vdp1_vram_arb #(
  parameter int NCH      = 3,
  parameter int AW       = 18,
  parameter int DW       = 16,
  parameter int MAXBURST = 16
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            CE,
  vdp1_vram_arb_if.slave  bus
);
  localparam int BLW = $clog2(MAXBURST) + 1;
  localparam int CW  = BLW - 1;
  localparam int PW  = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {IDLE, XFER, FIN} state_t;

  state_t         state, state_nxt;
  logic [PW-1:0]  cur, cur_nxt;
  logic           is_wr, is_wr_nxt;
  logic [CW-1:0]  last, last_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic [NCH-1:0] gnt, gnt_nxt;
  logic [NCH-1:0] rvalid, rvalid_nxt;
  logic [NCH-1:0] done, done_nxt;
  logic [DW-1:0]  rdata, rdata_nxt;
  logic [CW-1:0]  ridx, ridx_nxt;
  logic [AW-1:0]  vram_a, vram_a_nxt;
  logic [DW-1:0]  vram_d, vram_d_nxt;
  logic [1:0]     vram_we, vram_we_nxt;
  logic           vram_rd, vram_rd_nxt;

  logic           any_req;
  logic [PW-1:0]  win;
  logic [1:0]     win_we;
  logic [AW-1:0]  win_a;
  logic [BLW-1:0] win_len;
  logic [DW-1:0]  win_d;
  logic [CW-1:0]  win_last;
  logic           take;

`ifdef VDP1_ARB_RR_EN
  logic [PW-1:0]  ptr, ptr_nxt;

  // Scan downward from the farthest offset so the channel nearest the pointer wins.
  always_comb begin
    win = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (bus.REQ[(int'(ptr) + i) % NCH]) win = PW'((int'(ptr) + i) % NCH);
    end
  end
`else
  always_comb begin
    win = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (bus.REQ[i]) win = PW'(i);
    end
  end
`endif

  assign any_req = |bus.REQ;
  assign win_we  = bus.REQ_WE[int'(win)*2 +: 2];
  assign win_a   = bus.REQ_A[int'(win)*AW +: AW];
  assign win_len = bus.REQ_LEN[int'(win)*BLW +: BLW];
  assign win_d   = bus.REQ_D[int'(win)*DW +: DW];

  // LEN=0 means one word; lengths beyond MAXBURST are clamped.
  always_comb begin
    if (win_len == '0)                   win_last = '0;
    else if (int'(win_len) > MAXBURST)   win_last = CW'(MAXBURST - 1);
    else                                 win_last = CW'(win_len - BLW'(1));
  end

  assign take = (state == XFER) && !is_wr && bus.VRAM_RDY && !vram_rd;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= IDLE;
      cur     <= '0;
      is_wr   <= 1'b0;
      last    <= '0;
      cnt     <= '0;
      gnt     <= '0;
      rvalid  <= '0;
      done    <= '0;
      rdata   <= '0;
      ridx    <= '0;
      vram_a  <= '0;
      vram_d  <= '0;
      vram_we <= '0;
      vram_rd <= 1'b0;
`ifdef VDP1_ARB_RR_EN
      ptr     <= '0;
`endif
    end else if (CE) begin
      state   <= state_nxt;
      cur     <= cur_nxt;
      is_wr   <= is_wr_nxt;
      last    <= last_nxt;
      cnt     <= cnt_nxt;
      gnt     <= gnt_nxt;
      rvalid  <= rvalid_nxt;
      done    <= done_nxt;
      rdata   <= rdata_nxt;
      ridx    <= ridx_nxt;
      vram_a  <= vram_a_nxt;
      vram_d  <= vram_d_nxt;
      vram_we <= vram_we_nxt;
      vram_rd <= vram_rd_nxt;
`ifdef VDP1_ARB_RR_EN
      ptr     <= ptr_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (any_req) state_nxt = XFER;
      XFER: begin
        if (is_wr) begin
          if (bus.VRAM_RDY) state_nxt = FIN;
        end else if (take && cnt == last) begin
          state_nxt = FIN;
        end
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Registered outputs: every pulse is held until the next enabled edge.
  always_comb begin
    cur_nxt     = cur;
    is_wr_nxt   = is_wr;
    last_nxt    = last;
    cnt_nxt     = cnt;
    gnt_nxt     = '0;
    rvalid_nxt  = '0;
    done_nxt    = '0;
    rdata_nxt   = rdata;
    ridx_nxt    = ridx;
    vram_a_nxt  = vram_a;
    vram_d_nxt  = vram_d;
    vram_we_nxt = vram_we;
    vram_rd_nxt = 1'b0;
`ifdef VDP1_ARB_RR_EN
    ptr_nxt     = ptr;
`endif
    case (state)
      IDLE: begin
        if (any_req) begin
          cur_nxt      = win;
          is_wr_nxt    = (win_we != 2'b00);
          last_nxt     = win_last;
          cnt_nxt      = '0;
          gnt_nxt[win] = 1'b1;
          vram_a_nxt   = win_a;
          if (win_we != 2'b00) begin
            vram_we_nxt = win_we;
            vram_d_nxt  = win_d;
          end else begin
            vram_rd_nxt = 1'b1;
          end
`ifdef VDP1_ARB_RR_EN
          ptr_nxt = PW'((int'(win) + 1) % NCH);
`endif
        end
      end
      XFER: begin
        if (is_wr) begin
          if (bus.VRAM_RDY) vram_we_nxt = 2'b00;
        end else if (take) begin
          rvalid_nxt[cur] = 1'b1;
          rdata_nxt       = bus.VRAM_Q;
          ridx_nxt        = cnt;
          if (cnt != last) begin
            vram_a_nxt  = vram_a + AW'(1);
            cnt_nxt     = cnt + CW'(1);
            vram_rd_nxt = 1'b1;
          end
        end
      end
      FIN: begin
        done_nxt[cur] = 1'b1;
        cnt_nxt       = '0;
      end
      default: ;
    endcase
  end

  assign bus.GNT     = gnt;
  assign bus.RVALID  = rvalid;
  assign bus.RDATA   = rdata;
  assign bus.RIDX    = ridx;
  assign bus.DONE    = done;
  assign bus.BUSY    = (state != IDLE);
  assign bus.VRAM_A  = vram_a;
  assign bus.VRAM_D  = vram_d;
  assign bus.VRAM_WE = vram_we;
  assign bus.VRAM_RD = vram_rd;
endmodule

// File: tb/tb_vdp1_vram_arb.sv
// Bench for vdp1_vram_arb: directed scenarios plus randomized transactions against a
// transaction-level model (grant order, expected words, write log).
module tb_vdp1_vram_arb;
  localparam int NCH = 3, AW = 18, DW = 16, MAXBURST = 16, BLW = 5;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  logic CE = 1'b1;

  vdp1_vram_arb_if #(.NCH(NCH), .AW(AW), .DW(DW), .MAXBURST(MAXBURST)) bus ();

  vdp1_vram_arb #(.NCH(NCH), .AW(AW), .DW(DW), .MAXBURST(MAXBURST)) dut (
    .CLK(CLK), .RST_N(RST_N), .CE(CE), .bus(bus)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int rdy_pct = 100;
  int ce_pct = 100;
  int model_ptr = 0;
  bit ce_q = 1'b0;

  int              gnt_log[$];
  int              done_log[$];
  int              rv_ch[$];
  int              rv_idx[$];
  logic [DW-1:0]   rv_data[$];
  logic [AW-1:0]   rd_log[$];
  logic [AW+DW+1:0] wr_log[$];

  function automatic logic [DW-1:0] vram_val(input logic [AW-1:0] a);
    return a[15:0] ^ {a[17:16], 14'h0};
  endfunction

  assign bus.VRAM_Q = vram_val(bus.VRAM_A);

  function automatic int model_pick(input logic [NCH-1:0] pend);
`ifdef VDP1_ARB_RR_EN
    for (int k = 0; k < NCH; k++) if (pend[(model_ptr + k) % NCH]) return (model_ptr + k) % NCH;
`else
    for (int k = 0; k < NCH; k++) if (pend[k]) return k;
`endif
    return -1;
  endfunction

  // Outputs only carry new information after an enabled edge; stretched pulses are logged once.
  always @(posedge CLK) ce_q <= CE;

  always @(negedge CLK) begin
    if (RST_N && ce_q) begin
      for (int c = 0; c < NCH; c++) begin
        if (bus.GNT[c]) gnt_log.push_back(c);
        if (bus.DONE[c]) done_log.push_back(c);
        if (bus.RVALID[c]) begin
          rv_ch.push_back(c);
          rv_data.push_back(bus.RDATA);
          rv_idx.push_back(int'(bus.RIDX));
        end
      end
      if (bus.VRAM_RD) rd_log.push_back(bus.VRAM_A);
    end
    if (RST_N && CE && bus.VRAM_WE != 2'b00 && bus.VRAM_RDY)
      wr_log.push_back({bus.VRAM_WE, bus.VRAM_A, bus.VRAM_D});
  end

  task automatic step();
    @(posedge CLK);
    #1;
    bus.VRAM_RDY = ($urandom_range(99) < rdy_pct);
    CE = ($urandom_range(99) < ce_pct);
  endtask

  task automatic clear_logs();
    gnt_log.delete(); done_log.delete(); rv_ch.delete(); rv_idx.delete();
    rv_data.delete(); rd_log.delete(); wr_log.delete();
  endtask

  task automatic set_chan(input int ch, input logic [1:0] we, input logic [AW-1:0] a,
                          input logic [BLW-1:0] len, input logic [DW-1:0] d);
    bus.REQ_WE[ch*2 +: 2]      = we;
    bus.REQ_A[ch*AW +: AW]     = a;
    bus.REQ_LEN[ch*BLW +: BLW] = len;
    bus.REQ_D[ch*DW +: DW]     = d;
  endtask

  task automatic wait_grants(input int n, output bit ok);
    for (int i = 0; i < 400 && gnt_log.size() < n; i++) step();
    ok = (gnt_log.size() >= n);
  endtask

  task automatic wait_dones(input int n, output bit ok);
    for (int i = 0; i < 2000 && done_log.size() < n; i++) step();
    ok = (done_log.size() >= n);
  endtask

  task automatic run_one(input int ch, input logic [1:0] we, input logic [AW-1:0] a,
                         input logic [BLW-1:0] len, input logic [DW-1:0] d, output bit ok);
    bit okg, okd;
    clear_logs();
    set_chan(ch, we, a, len, d);
    bus.REQ[ch] = 1'b1;
    wait_grants(1, okg);
    bus.REQ[ch] = 1'b0;
    wait_dones(1, okd);
    step();
    step();
    ok = okg && okd;
  endtask

  task automatic test_reset();
    checks++;
    if ({bus.GNT, bus.RVALID, bus.DONE, bus.BUSY} !== 10'h0) begin
      errors++; $display("FAIL reset_pulses got %h exp 000", {bus.GNT, bus.RVALID, bus.DONE, bus.BUSY});
    end
    checks++;
    if ({bus.VRAM_RD, bus.VRAM_WE, bus.VRAM_A, bus.VRAM_D, bus.RDATA, bus.RIDX} !== 57'h0) begin
      errors++; $display("FAIL reset_bus got %h exp 0",
                         {bus.VRAM_RD, bus.VRAM_WE, bus.VRAM_A, bus.VRAM_D, bus.RDATA, bus.RIDX});
    end
    RST_N = 1'b1;
    step(); step();
    clear_logs();
    set_chan(1, 2'b00, 18'h00200, 5'd16, 16'h0);
    bus.REQ = 3'b010;
    for (int i = 0; i < 100 && rv_ch.size() < 3; i++) step();
    checks++;
    if (rv_ch.size() < 3 || bus.BUSY !== 1'b1) begin
      errors++; $display("FAIL reset_burst_start words %0d busy %b exp >=3 and 1", rv_ch.size(), bus.BUSY);
    end
    bus.REQ = 3'b000;
    #2 RST_N = 1'b0;
    #1;
    checks++;
    if ({bus.VRAM_RD, bus.VRAM_WE} !== 3'b000) begin
      errors++; $display("FAIL reset_strobes got %b exp 000", {bus.VRAM_RD, bus.VRAM_WE});
    end
    checks++;
    if ({bus.GNT, bus.RVALID, bus.DONE, bus.BUSY} !== 10'h0) begin
      errors++; $display("FAIL reset_midburst got %h exp 000", {bus.GNT, bus.RVALID, bus.DONE, bus.BUSY});
    end
    #10 RST_N = 1'b1;
    model_ptr = 0;
    clear_logs();
    repeat (12) step();
    checks++;
    if (done_log.size() != 0 || gnt_log.size() != 0 || bus.BUSY !== 1'b0) begin
      errors++; $display("FAIL reset_after dones %0d grants %0d busy %b exp 0 0 0",
                         done_log.size(), gnt_log.size(), bus.BUSY);
    end
  endtask

  task automatic test_single_write();
    bit ok;
    int exp;
    clear_logs();
    rdy_pct = 0; ce_pct = 100; bus.VRAM_RDY = 1'b0;
    set_chan(0, 2'b11, 18'h00010, 5'd0, 16'hBEEF);
    bus.REQ[0] = 1'b1;
    wait_grants(1, ok);
    bus.REQ[0] = 1'b0;
    exp = model_pick(3'b001);
    model_ptr = (exp + 1) % NCH;
    checks++;
    if (!ok || gnt_log[0] != exp) begin
      errors++; $display("FAIL wr_grant got %0d exp %0d", ok ? gnt_log[0] : -1, exp);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({bus.VRAM_WE, bus.VRAM_A, bus.VRAM_D} !== {2'b11, 18'h00010, 16'hBEEF}) begin
        errors++; $display("FAIL wr_hold cyc %0d got %h exp %h", i,
                           {bus.VRAM_WE, bus.VRAM_A, bus.VRAM_D}, {2'b11, 18'h00010, 16'hBEEF});
      end
    end
    rdy_pct = 100; bus.VRAM_RDY = 1'b1;
    wait_dones(1, ok);
    rdy_pct = 0;
    repeat (4) step();
    checks++;
    if (!ok || done_log.size() != 1 || done_log[0] != 0) begin
      errors++; $display("FAIL wr_done count %0d exp 1 on ch0", done_log.size());
    end
    checks++;
    if (wr_log.size() != 1 || wr_log[0] !== {2'b11, 18'h00010, 16'hBEEF}) begin
      errors++; $display("FAIL wr_bus writes %0d got %h exp %h", wr_log.size(),
                         wr_log.size() > 0 ? wr_log[0] : 36'h0, {2'b11, 18'h00010, 16'hBEEF});
    end
    checks++;
    if ({bus.BUSY, bus.VRAM_WE} !== 3'b000) begin
      errors++; $display("FAIL wr_idle got %b exp 000", {bus.BUSY, bus.VRAM_WE});
    end
  endtask

  task automatic test_burst_read();
    bit ok;
    int bad;
    rdy_pct = 50; ce_pct = 100;
    run_one(1, 2'b00, 18'h00100, 5'd16, 16'h0, ok);
    model_ptr = (model_pick(3'b010) + 1) % NCH;
    checks++;
    if (!ok || rv_ch.size() != 16 || rd_log.size() != 16) begin
      errors++; $display("FAIL burst_count ok %0b words %0d strobes %0d exp 16 16", ok, rv_ch.size(), rd_log.size());
    end
    for (int i = 0; i < 16 && i < rv_ch.size(); i++) begin
      checks++;
      if ({rv_ch[i], rv_idx[i], rv_data[i]} !== {1, i, vram_val(18'h00100 + AW'(i))}) begin
        errors++; $display("FAIL burst_word %0d got ch %0d idx %0d data %h exp ch 1 idx %0d data %h",
                           i, rv_ch[i], rv_idx[i], rv_data[i], i, vram_val(18'h00100 + AW'(i)));
      end
    end
    bad = 0;
    for (int i = 0; i < rd_log.size(); i++) if (rd_log[i] !== 18'h00100 + AW'(i)) bad++;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL burst_addr got %0d wrong strobe addresses exp 0", bad);
    end
    checks++;
    if (done_log.size() != 1 || done_log[0] != 1) begin
      errors++; $display("FAIL burst_done count %0d exp 1 on ch1", done_log.size());
    end
  endtask

  task automatic test_len0_wrap();
    bit ok;
    rdy_pct = 100; ce_pct = 100;
    run_one(2, 2'b00, 18'h3FFFF, 5'd0, 16'h0, ok);
    model_ptr = (model_pick(3'b100) + 1) % NCH;
    checks++;
    if (!ok || rv_ch.size() != 1 || rd_log.size() != 1 || rv_data[0] !== vram_val(18'h3FFFF)) begin
      errors++; $display("FAIL len0 words %0d strobes %0d exp 1 1 data %h", rv_ch.size(), rd_log.size(),
                         vram_val(18'h3FFFF));
    end
    run_one(2, 2'b00, 18'h3FFFF, 5'd2, 16'h0, ok);
    model_ptr = (model_pick(3'b100) + 1) % NCH;
    checks++;
    if (!ok || rd_log.size() != 2 || rd_log[0] !== 18'h3FFFF || rd_log[1] !== 18'h00000) begin
      errors++; $display("FAIL wrap_addr strobes %0d first %h second %h exp 2 3ffff 00000", rd_log.size(),
                         rd_log.size() > 0 ? rd_log[0] : 18'h0, rd_log.size() > 1 ? rd_log[1] : 18'h0);
    end
    checks++;
    if (rv_ch.size() != 2 || rv_data[1] !== vram_val(18'h0) || rv_idx[1] != 1) begin
      errors++; $display("FAIL wrap_data words %0d exp 2 with word1 %h idx 1", rv_ch.size(), vram_val(18'h0));
    end
  endtask

  task automatic test_contention();
    bit ok;
    logic [NCH-1:0] pend;
    int exp, got;
    rdy_pct = 100; ce_pct = 100;
    clear_logs();
    for (int c = 0; c < NCH; c++) set_chan(c, 2'b00, AW'(18'h01000 + 16 * c), 5'd1, 16'h0);
    pend = 3'b111;
    bus.REQ = 3'b111;
    for (int g = 0; g < NCH; g++) begin
      wait_grants(g + 1, ok);
      exp = model_pick(pend);
      got = ok ? gnt_log[g] : -1;
      checks++;
      if (got != exp) begin
        errors++; $display("FAIL contend_grant %0d got ch %0d exp ch %0d", g, got, exp);
      end
      if (got >= 0) bus.REQ[got] = 1'b0;
      pend[exp] = 1'b0;
      model_ptr = (exp + 1) % NCH;
    end
    bus.REQ = 3'b000;
    wait_dones(NCH, ok);
    step(); step();
    checks++;
    if (!ok || done_log.size() != NCH || gnt_log.size() != NCH) begin
      errors++; $display("FAIL contend_done dones %0d grants %0d exp 3 3", done_log.size(), gnt_log.size());
    end
  endtask

  task automatic test_continuous();
    bit ok;
    int exp;
    rdy_pct = 100; ce_pct = 100;
    clear_logs();
    for (int c = 0; c < NCH; c++) set_chan(c, 2'b01, AW'(18'h02000 + c), 5'd0, DW'(16'hA000 + c));
    bus.REQ = 3'b111;
    wait_grants(6, ok);
    bus.REQ = 3'b000;
    for (int i = 0; i < 400 && (done_log.size() < gnt_log.size() || bus.BUSY); i++) step();
    checks++;
    if (!ok || done_log.size() != gnt_log.size()) begin
      errors++; $display("FAIL cont_count grants %0d dones %0d exp >=6 equal", gnt_log.size(), done_log.size());
    end
    for (int g = 0; g < gnt_log.size(); g++) begin
      exp = model_pick(3'b111);
      checks++;
      if (gnt_log[g] != exp) begin
        errors++; $display("FAIL cont_grant %0d got ch %0d exp ch %0d", g, gnt_log[g], exp);
      end
      model_ptr = (exp + 1) % NCH;
    end
  endtask

  task automatic test_random();
    bit ok;
    int ch, n, bad;
    logic [1:0] we;
    logic [AW-1:0] a;
    logic [BLW-1:0] len;
    logic [DW-1:0] d;
    rdy_pct = 60; ce_pct = 80;
    for (int t = 0; t < 40; t++) begin
      ch  = $urandom_range(NCH - 1);
      we  = ($urandom_range(3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      a   = ($urandom_range(3) == 0) ? AW'(18'h3FFFF - $urandom_range(5)) : AW'($urandom);
      len = BLW'($urandom_range(0, 16));
      d   = DW'($urandom);
      run_one(ch, we, a, len, d, ok);
      model_ptr = (ch + 1) % NCH;
      checks++;
      if (!ok || gnt_log.size() != 1 || gnt_log[0] != ch || done_log.size() != 1 || done_log[0] != ch) begin
        errors++; $display("FAIL rnd_handshake t%0d grants %0d dones %0d exp one each on ch %0d",
                           t, gnt_log.size(), done_log.size(), ch);
      end
      if (we != 2'b00) begin
        checks++;
        if (wr_log.size() != 1 || wr_log[0] !== {we, a, d} || rv_ch.size() != 0) begin
          errors++; $display("FAIL rnd_write t%0d writes %0d got %h exp %h", t, wr_log.size(),
                             wr_log.size() > 0 ? wr_log[0] : 36'h0, {we, a, d});
        end
      end else begin
        n = (len == 0) ? 1 : int'(len);
        bad = 0;
        for (int i = 0; i < n && i < rv_ch.size() && i < rd_log.size(); i++) begin
          if (rv_ch[i] != ch || rv_idx[i] != i || rv_data[i] !== vram_val(a + AW'(i)) ||
              rd_log[i] !== a + AW'(i)) bad++;
        end
        checks++;
        if (rv_ch.size() != n || rd_log.size() != n || bad != 0 || wr_log.size() != 0) begin
          errors++; $display("FAIL rnd_read t%0d words %0d strobes %0d bad %0d exp %0d %0d 0",
                             t, rv_ch.size(), rd_log.size(), bad, n, n);
        end
      end
    end
  endtask

  initial begin
    bus.REQ = '0; bus.REQ_WE = '0; bus.REQ_A = '0; bus.REQ_LEN = '0; bus.REQ_D = '0;
    bus.VRAM_RDY = 1'b0;
    #23;
    test_reset();
    test_single_write();
    test_burst_read();
    test_len0_wrap();
    test_contention();
    test_continuous();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end
endmodule
